alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Issue-side partner of the ALU execute unit in the Tomasulo core.
- Holds up to NUM_ENTRIES renamed ALU micro-ops and snoops the common data bus (CDB) for missing operand values and NZCV flags.
- Sends the oldest fully-ready entry to the ALU through a one-deep registered dispatch stage with valid/ready handshake.

Parameters:
- NUM_ENTRIES, 4, number of station slots (>=2).
- TAG_WIDTH, 4, ROB tag width.
- GPR_SIZE, 64, operand width (matches `GPR_SIZE).

Ports:
- in_clk  input  1  clock.
- in_rst_n  input  1  asynchronous active-low reset.
- in_flush  input  1  synchronous squash of all entries and the dispatch register.
- in_ins_valid  input  1  insert request.
- out_ins_ready  output  1  station can accept an insert.
- in_ins_alu_op  input  alu_op_t  operation.
- in_ins_val_a / in_ins_val_b  input  GPR_SIZE  operand values, meaningful when the matching ready bit is set.
- in_ins_a_ready / in_ins_b_ready  input  1  operand already available.
- in_ins_a_tag / in_ins_b_tag  input  TAG_WIDTH  producer tag when not ready.
- in_ins_nzcv  input  nzcv_t  flags value; in_ins_nzcv_ready input 1; in_ins_nzcv_tag input TAG_WIDTH.
- in_ins_hw  input  6  MOV shift; in_ins_set_CC input 1; in_ins_cond input cond_t.
- in_ins_dst_tag  input  TAG_WIDTH  destination ROB tag.
- in_cdb_valid  input  1  CDB broadcast valid.
- in_cdb_tag  input  TAG_WIDTH; in_cdb_value input GPR_SIZE.
- in_cdb_set_nzcv  input  1  broadcast carries flags; in_cdb_nzcv input nzcv_t.
- out_fu_valid  output  1  dispatch register holds an op.
- in_fu_ready  input  1  ALU accepts the op this cycle.
- out_fu_alu_op, out_fu_val_a, out_fu_val_b, out_fu_hw, out_fu_set_CC, out_fu_cond, out_fu_prev_nzcv, out_fu_dst_tag  output  (as insert fields)  dispatched op.
- out_count  output  $clog2(NUM_ENTRIES+1)  occupied entries.

Behaviour:
- Reset (async assert, sync release): all entries invalid; out_count=0; out_ins_ready=1; out_fu_valid=0; every out_fu_* field=0.
- Storage is a collapsing queue. Slot 0 is the oldest. The valid slots are always 0..count-1.
- Insert happens when in_ins_valid & out_ins_ready. out_ins_ready = (count < NUM_ENTRIES) from registered count. Same-cycle dispatch does not free a slot for that cycle's insert.
- Insert position is count, or count-1 when an entry leaves the queue in the same cycle.
- Wakeup: when in_cdb_valid and a slot is waiting on an operand whose tag equals in_cdb_tag, the slot captures in_cdb_value and sets that ready bit at the clock edge. NZCV wakes up the same way, but also requires in_cdb_set_nzcv. A and B may wake on the same broadcast.
- Insert bypass: an inserting op waiting on a tag equal to the same-cycle CDB tag captures the broadcast value and is stored ready.
- Eligibility: a slot is eligible when a_ready, b_ready and nzcv_ready are all registered set. A slot woken this cycle becomes eligible next cycle.
- Select: the lowest-index eligible slot.
- Dispatch register load: when (!out_fu_valid | in_fu_ready) and an eligible slot exists, that slot moves into out_fu_* at the edge, out_fu_valid=1, and higher slots shift down by one.
- If in_fu_ready=1 and no slot is eligible, out_fu_valid clears.
- While out_fu_valid & !in_fu_ready, all out_fu_* fields hold stable.
- Minimum latency: an op inserted all-ready at edge E0 shows out_fu_valid=1 after edge E1. With the register free, throughput is one op per cycle.
- Flush has priority over insert, wakeup and dispatch. After the edge: all slots invalid, count=0, out_fu_valid=0. The values on out_fu_* are don't-care.
- count next = count + insert − leave, saturating at no bound. An overflow is impossible by construction, and an assertion checks count ≤ NUM_ENTRIES.

Test Plan:
- Reset then insert ADD with a_ready=1 (val_a=5), b_ready=1 (val_b=7), dst_tag=3, in_fu_ready=1 -> out_fu_valid rises two edges after insert, with out_fu_val_a=5, out_fu_val_b=7, out_fu_dst_tag=3; out_count returns to 0.
- Insert op with b waiting on tag 9, then a CDB broadcast tag=9 value=0x1234 two cycles later -> dispatch happens exactly one edge after the capture edge, with out_fu_val_b=0x1234. A broadcast tag=8 causes no wakeup.
- Insert a CSEL op waiting on nzcv tag 2; broadcast tag=2 with set_nzcv=0 -> no wakeup; broadcast with set_nzcv=1, nzcv=4'b0100 -> dispatch with out_fu_prev_nzcv=4'b0100.
- Fill 4 entries with in_fu_ready=0 -> out_ins_ready=0 and out_count=4. A 5th insert is ignored. Raise in_fu_ready -> ops leave in insertion order, one per cycle.
- Slots 0 (not ready) and 1 (ready): slot 1 dispatches first. Slot 0 then shifts to 0 and dispatches after its wakeup, so ordering is by age among eligible slots.
- Assert in_flush with 3 entries and out_fu_valid=1, together with a simultaneous insert -> after the edge, count=0, out_fu_valid=0 and the insert is dropped. Async reset mid-stall clears everything immediately.

Source files
------------

// File: rtl/alu_reservation_station.sv
// ALU reservation station: a collapsing queue of renamed ALU micro-ops.
// Each entry snoops the CDB for missing operands and flags. The oldest
// fully-ready entry is moved into a one-deep registered dispatch stage.

package alu_rs_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_ORR  = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_MOV  = 4'd5,
    ALU_CSEL = 4'd6,
    ALU_LSL  = 4'd7,
    ALU_LSR  = 4'd8,
    ALU_ASR  = 4'd9
  } alu_op_t;

  typedef logic [3:0] nzcv_t;
  typedef logic [3:0] cond_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = 4,
  parameter int GPR_SIZE    = 64,
  localparam int CW = $clog2(NUM_ENTRIES + 1),
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_flush,
  input  logic                 in_ins_valid,
  output logic                 out_ins_ready,
  input  alu_op_t              in_ins_alu_op,
  input  logic [GPR_SIZE-1:0]  in_ins_val_a,
  input  logic [GPR_SIZE-1:0]  in_ins_val_b,
  input  logic                 in_ins_a_ready,
  input  logic                 in_ins_b_ready,
  input  logic [TAG_WIDTH-1:0] in_ins_a_tag,
  input  logic [TAG_WIDTH-1:0] in_ins_b_tag,
  input  nzcv_t                in_ins_nzcv,
  input  logic                 in_ins_nzcv_ready,
  input  logic [TAG_WIDTH-1:0] in_ins_nzcv_tag,
  input  logic [5:0]           in_ins_hw,
  input  logic                 in_ins_set_CC,
  input  cond_t                in_ins_cond,
  input  logic [TAG_WIDTH-1:0] in_ins_dst_tag,
  input  logic                 in_cdb_valid,
  input  logic [TAG_WIDTH-1:0] in_cdb_tag,
  input  logic [GPR_SIZE-1:0]  in_cdb_value,
  input  logic                 in_cdb_set_nzcv,
  input  nzcv_t                in_cdb_nzcv,
  output logic                 out_fu_valid,
  input  logic                 in_fu_ready,
  output alu_op_t              out_fu_alu_op,
  output logic [GPR_SIZE-1:0]  out_fu_val_a,
  output logic [GPR_SIZE-1:0]  out_fu_val_b,
  output logic [5:0]           out_fu_hw,
  output logic                 out_fu_set_CC,
  output cond_t                out_fu_cond,
  output nzcv_t                out_fu_prev_nzcv,
  output logic [TAG_WIDTH-1:0] out_fu_dst_tag,
  output logic [CW-1:0]        out_count
);

  typedef struct packed {
    alu_op_t              alu_op;
    logic [GPR_SIZE-1:0]  val_a;
    logic [GPR_SIZE-1:0]  val_b;
    logic                 a_ready;
    logic                 b_ready;
    logic [TAG_WIDTH-1:0] a_tag;
    logic [TAG_WIDTH-1:0] b_tag;
    nzcv_t                nzcv;
    logic                 nzcv_ready;
    logic [TAG_WIDTH-1:0] nzcv_tag;
    logic [5:0]           hw;
    logic                 set_cc;
    cond_t                cond;
    logic [TAG_WIDTH-1:0] dst_tag;
  } entry_t;

  entry_t                 slots      [NUM_ENTRIES];
  entry_t                 woken      [NUM_ENTRIES];
  entry_t                 slots_next [NUM_ENTRIES];
  entry_t                 new_entry;
  entry_t                 sel_entry;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic [CW-1:0]          ins_pos;
  logic [NUM_ENTRIES-1:0] eligible;
  logic                   sel_found;
  logic [IW-1:0]          sel_idx;
  logic                   do_insert;
  logic                   do_leave;

  assign out_count     = count;
  assign out_ins_ready = (count < CW'(NUM_ENTRIES));
  assign do_insert     = in_ins_valid && out_ins_ready;
  assign do_leave      = sel_found && (!out_fu_valid || in_fu_ready);
  assign ins_pos       = count - CW'(do_leave);
  assign count_next    = count + CW'(do_insert) - CW'(do_leave);
  assign sel_entry     = slots[sel_idx];

  // Build the incoming entry, capturing any operand the CDB delivers this same cycle
  always_comb begin
    new_entry            = '0;
    new_entry.alu_op     = in_ins_alu_op;
    new_entry.val_a      = in_ins_val_a;
    new_entry.val_b      = in_ins_val_b;
    new_entry.a_ready    = in_ins_a_ready;
    new_entry.b_ready    = in_ins_b_ready;
    new_entry.a_tag      = in_ins_a_tag;
    new_entry.b_tag      = in_ins_b_tag;
    new_entry.nzcv       = in_ins_nzcv;
    new_entry.nzcv_ready = in_ins_nzcv_ready;
    new_entry.nzcv_tag   = in_ins_nzcv_tag;
    new_entry.hw         = in_ins_hw;
    new_entry.set_cc     = in_ins_set_CC;
    new_entry.cond       = in_ins_cond;
    new_entry.dst_tag    = in_ins_dst_tag;
    if (in_cdb_valid) begin
      if (!in_ins_a_ready && in_ins_a_tag == in_cdb_tag) begin
        new_entry.val_a   = in_cdb_value;
        new_entry.a_ready = 1'b1;
      end
      if (!in_ins_b_ready && in_ins_b_tag == in_cdb_tag) begin
        new_entry.val_b   = in_cdb_value;
        new_entry.b_ready = 1'b1;
      end
      if (in_cdb_set_nzcv && !in_ins_nzcv_ready && in_ins_nzcv_tag == in_cdb_tag) begin
        new_entry.nzcv       = in_cdb_nzcv;
        new_entry.nzcv_ready = 1'b1;
      end
    end
  end

  // Apply CDB wakeup to every stored entry waiting on the broadcast tag
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woken[i] = slots[i];
      if (in_cdb_valid) begin
        if (!slots[i].a_ready && slots[i].a_tag == in_cdb_tag) begin
          woken[i].val_a   = in_cdb_value;
          woken[i].a_ready = 1'b1;
        end
        if (!slots[i].b_ready && slots[i].b_tag == in_cdb_tag) begin
          woken[i].val_b   = in_cdb_value;
          woken[i].b_ready = 1'b1;
        end
        if (in_cdb_set_nzcv && !slots[i].nzcv_ready && slots[i].nzcv_tag == in_cdb_tag) begin
          woken[i].nzcv       = in_cdb_nzcv;
          woken[i].nzcv_ready = 1'b1;
        end
      end
    end
  end

  // Pick the oldest occupied slot whose registered ready bits are all set
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      eligible[i] = (CW'(i) < count) && slots[i].a_ready && slots[i].b_ready
                    && slots[i].nzcv_ready;
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Collapse the queue above a leaving slot and drop the new entry at the tail
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      slots_next[i] = woken[i];
      if (do_leave && IW'(i) >= sel_idx) begin
        slots_next[i] = woken[i + 1];
      end
    end
    slots_next[NUM_ENTRIES - 1] = woken[NUM_ENTRIES - 1];
    if (do_insert) begin
      slots_next[IW'(ins_pos)] = new_entry;
    end
  end

  // Station storage and occupancy; flush empties the queue
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slots[i] <= '0;
      end
    end else if (in_flush) begin
      count <= '0;
    end else begin
      count <= count_next;
      slots <= slots_next;
    end
  end

  // Dispatch register: load when free or draining, hold while the ALU stalls
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_fu_valid     <= 1'b0;
      out_fu_alu_op    <= ALU_ADD;
      out_fu_val_a     <= '0;
      out_fu_val_b     <= '0;
      out_fu_hw        <= '0;
      out_fu_set_CC    <= 1'b0;
      out_fu_cond      <= '0;
      out_fu_prev_nzcv <= '0;
      out_fu_dst_tag   <= '0;
    end else if (in_flush) begin
      out_fu_valid <= 1'b0;
    end else if (do_leave) begin
      out_fu_valid     <= 1'b1;
      out_fu_alu_op    <= sel_entry.alu_op;
      out_fu_val_a     <= sel_entry.val_a;
      out_fu_val_b     <= sel_entry.val_b;
      out_fu_hw        <= sel_entry.hw;
      out_fu_set_CC    <= sel_entry.set_cc;
      out_fu_cond      <= sel_entry.cond;
      out_fu_prev_nzcv <= sel_entry.nzcv;
      out_fu_dst_tag   <= sel_entry.dst_tag;
    end else if (in_fu_ready) begin
      out_fu_valid <= 1'b0;
    end
  end

  count_bound: assert property (@(posedge in_clk) disable iff (!in_rst_n)
                                count <= CW'(NUM_ENTRIES));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a cycle table for the main
// insert/wakeup/dispatch flows plus hand sequences for flags, flush and reset.

module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  logic          in_clk;
  logic          in_rst_n;
  logic          in_flush;
  logic          in_ins_valid;
  logic          out_ins_ready;
  alu_op_t       in_ins_alu_op;
  logic [63:0]   in_ins_val_a;
  logic [63:0]   in_ins_val_b;
  logic          in_ins_a_ready;
  logic          in_ins_b_ready;
  logic [3:0]    in_ins_a_tag;
  logic [3:0]    in_ins_b_tag;
  nzcv_t         in_ins_nzcv;
  logic          in_ins_nzcv_ready;
  logic [3:0]    in_ins_nzcv_tag;
  logic [5:0]    in_ins_hw;
  logic          in_ins_set_CC;
  cond_t         in_ins_cond;
  logic [3:0]    in_ins_dst_tag;
  logic          in_cdb_valid;
  logic [3:0]    in_cdb_tag;
  logic [63:0]   in_cdb_value;
  logic          in_cdb_set_nzcv;
  nzcv_t         in_cdb_nzcv;
  logic          out_fu_valid;
  logic          in_fu_ready;
  alu_op_t       out_fu_alu_op;
  logic [63:0]   out_fu_val_a;
  logic [63:0]   out_fu_val_b;
  logic [5:0]    out_fu_hw;
  logic          out_fu_set_CC;
  cond_t         out_fu_cond;
  nzcv_t         out_fu_prev_nzcv;
  logic [3:0]    out_fu_dst_tag;
  logic [2:0]    out_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic        ar;
    logic        br;
    logic [63:0] va;
    logic [63:0] vb;
    logic [3:0]  at;
    logic [3:0]  bt;
    logic [3:0]  dt;
    logic        cv;
    logic [3:0]  ct;
    logic [63:0] cval;
    logic        fr;
    logic        ev;
    logic [2:0]  ec;
    logic        er;
    logic [3:0]  ed;
    logic [63:0] ea;
    logic [63:0] eb;
  } vec_t;

  vec_t vecs[$];

  alu_reservation_station dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_flush(in_flush),
    .in_ins_valid(in_ins_valid), .out_ins_ready(out_ins_ready),
    .in_ins_alu_op(in_ins_alu_op), .in_ins_val_a(in_ins_val_a), .in_ins_val_b(in_ins_val_b),
    .in_ins_a_ready(in_ins_a_ready), .in_ins_b_ready(in_ins_b_ready),
    .in_ins_a_tag(in_ins_a_tag), .in_ins_b_tag(in_ins_b_tag),
    .in_ins_nzcv(in_ins_nzcv), .in_ins_nzcv_ready(in_ins_nzcv_ready),
    .in_ins_nzcv_tag(in_ins_nzcv_tag), .in_ins_hw(in_ins_hw),
    .in_ins_set_CC(in_ins_set_CC), .in_ins_cond(in_ins_cond),
    .in_ins_dst_tag(in_ins_dst_tag), .in_cdb_valid(in_cdb_valid),
    .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_set_nzcv(in_cdb_set_nzcv), .in_cdb_nzcv(in_cdb_nzcv),
    .out_fu_valid(out_fu_valid), .in_fu_ready(in_fu_ready),
    .out_fu_alu_op(out_fu_alu_op), .out_fu_val_a(out_fu_val_a),
    .out_fu_val_b(out_fu_val_b), .out_fu_hw(out_fu_hw),
    .out_fu_set_CC(out_fu_set_CC), .out_fu_cond(out_fu_cond),
    .out_fu_prev_nzcv(out_fu_prev_nzcv), .out_fu_dst_tag(out_fu_dst_tag),
    .out_count(out_count)
  );

  // Free-running 10-unit clock
  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic clearInputs();
    in_flush          = 1'b0;
    in_ins_valid      = 1'b0;
    in_ins_alu_op     = ALU_ADD;
    in_ins_val_a      = '0;
    in_ins_val_b      = '0;
    in_ins_a_ready    = 1'b1;
    in_ins_b_ready    = 1'b1;
    in_ins_a_tag      = '0;
    in_ins_b_tag      = '0;
    in_ins_nzcv       = '0;
    in_ins_nzcv_ready = 1'b1;
    in_ins_nzcv_tag   = '0;
    in_ins_hw         = '0;
    in_ins_set_CC     = 1'b0;
    in_ins_cond       = '0;
    in_ins_dst_tag    = '0;
    in_cdb_valid      = 1'b0;
    in_cdb_tag        = '0;
    in_cdb_value      = '0;
    in_cdb_set_nzcv   = 1'b0;
    in_cdb_nzcv       = '0;
    in_fu_ready       = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    in_ins_valid   = v.iv;
    in_ins_a_ready = v.ar;
    in_ins_b_ready = v.br;
    in_ins_val_a   = v.va;
    in_ins_val_b   = v.vb;
    in_ins_a_tag   = v.at;
    in_ins_b_tag   = v.bt;
    in_ins_dst_tag = v.dt;
    in_cdb_valid   = v.cv;
    in_cdb_tag     = v.ct;
    in_cdb_value   = v.cval;
    in_fu_ready    = v.fr;
  endtask

  task automatic addVec(input logic iv, input logic ar, input logic br,
                        input logic [63:0] va, input logic [63:0] vb,
                        input logic [3:0] at, input logic [3:0] bt, input logic [3:0] dt,
                        input logic cv, input logic [3:0] ct, input logic [63:0] cval,
                        input logic fr, input logic ev, input logic [2:0] ec, input logic er,
                        input logic [3:0] ed, input logic [63:0] ea, input logic [63:0] eb);
    vec_t v;
    v.iv = iv; v.ar = ar; v.br = br; v.va = va; v.vb = vb;
    v.at = at; v.bt = bt; v.dt = dt; v.cv = cv; v.ct = ct; v.cval = cval;
    v.fr = fr; v.ev = ev; v.ec = ec; v.er = er; v.ed = ed; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  initial begin
    // All-ready ADD: inserted at one edge, in the dispatch register after the next
    addVec(1,1,1, 64'h5, 64'h7, 0,0,3,  0,0,0,          1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 3, 64'h5, 64'h7);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // B waits on tag 9; tag 8 is ignored, tag 9 wakes it, dispatch one edge later
    addVec(1,1,0, 64'h1, 0, 0,9,4,      0,0,0,          1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          1,8,64'hdead,   1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          1,9,64'h1234,   1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 4, 64'h1, 64'h1234);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // Stalled ALU: first op parks in the register, four more fill the station, sixth dropped
    addVec(1,1,1, 64'h11, 64'h21, 0,0,1, 0,0,0,         0,  0,1,1, 0, 0, 0);
    addVec(1,1,1, 64'h12, 64'h22, 0,0,2, 0,0,0,         0,  1,1,1, 1, 64'h11, 64'h21);
    addVec(1,1,1, 64'h13, 64'h23, 0,0,3, 0,0,0,         0,  1,2,1, 1, 64'h11, 64'h21);
    addVec(1,1,1, 64'h14, 64'h24, 0,0,4, 0,0,0,         0,  1,3,1, 1, 64'h11, 64'h21);
    addVec(1,1,1, 64'h15, 64'h25, 0,0,5, 0,0,0,         0,  1,4,0, 1, 64'h11, 64'h21);
    addVec(1,1,1, 64'h16, 64'h26, 0,0,6, 0,0,0,         0,  1,4,0, 1, 64'h11, 64'h21);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,3,1, 2, 64'h12, 64'h22);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,2,1, 3, 64'h13, 64'h23);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,1,1, 4, 64'h14, 64'h24);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 5, 64'h15, 64'h25);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // Younger ready op overtakes an older waiting one; older goes once woken
    addVec(1,0,1, 0, 64'h77, 5,0,7,     0,0,0,          1,  0,1,1, 0, 0, 0);
    addVec(1,1,1, 64'h88, 64'h99, 0,0,8, 0,0,0,         1,  0,2,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          1,5,64'h55,     1,  1,1,1, 8, 64'h88, 64'h99);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 7, 64'h55, 64'h77);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // Insert in the same cycle as a leave lands at count-1
    addVec(1,1,1, 64'h1, 64'h2, 0,0,9,  0,0,0,          1,  0,1,1, 0, 0, 0);
    addVec(1,1,1, 64'h3, 64'h4, 0,0,10, 0,0,0,          1,  1,1,1, 9, 64'h1, 64'h2);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 10, 64'h3, 64'h4);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // A and B both wake on one broadcast
    addVec(1,0,0, 0, 0, 6,6,11,         0,0,0,          1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          1,6,64'h66,     1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 11, 64'h66, 64'h66);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);
    // Insert bypass: operand arrives on the CDB in the insert cycle
    addVec(1,0,1, 0, 64'h5, 7,0,12,     1,7,64'h70,     1,  0,1,1, 0, 0, 0);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  1,0,1, 12, 64'h70, 64'h5);
    addVec(0,1,1, 0, 0, 0,0,0,          0,0,0,          1,  0,0,1, 0, 0, 0);

    clearInputs();
    in_rst_n = 1'b0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    #1;
    $display("[TB] reset released");
    checkOutput("reset count", 64'(out_count), 64'd0);
    checkOutput("reset ins_ready", 64'(out_ins_ready), 64'd1);
    checkOutput("reset fu_valid", 64'(out_fu_valid), 64'd0);
    checkOutput("reset fu_val_a", out_fu_val_a, 64'd0);
    checkOutput("reset fu_dst_tag", 64'(out_fu_dst_tag), 64'd0);
    checkOutput("reset fu_alu_op", 64'(out_fu_alu_op), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d fu_valid", i), 64'(out_fu_valid), 64'(vecs[i].ev));
      checkOutput($sformatf("vec%0d count", i), 64'(out_count), 64'(vecs[i].ec));
      checkOutput($sformatf("vec%0d ins_ready", i), 64'(out_ins_ready), 64'(vecs[i].er));
      if (vecs[i].ev) begin
        checkOutput($sformatf("vec%0d dst_tag", i), 64'(out_fu_dst_tag), 64'(vecs[i].ed));
        checkOutput($sformatf("vec%0d val_a", i), out_fu_val_a, vecs[i].ea);
        checkOutput($sformatf("vec%0d val_b", i), out_fu_val_b, vecs[i].eb);
      end
    end

    // NZCV wakeup needs set_nzcv as well as a tag match
    $display("[TB] nzcv wakeup sequence");
    clearInputs();
    in_ins_valid      = 1'b1;
    in_ins_alu_op     = ALU_CSEL;
    in_ins_val_a      = 64'hA;
    in_ins_val_b      = 64'hB;
    in_ins_nzcv_ready = 1'b0;
    in_ins_nzcv_tag   = 4'd2;
    in_ins_hw         = 6'd3;
    in_ins_set_CC     = 1'b1;
    in_ins_cond       = 4'd5;
    in_ins_dst_tag    = 4'd13;
    tick();
    clearInputs();
    in_cdb_valid = 1'b1;
    in_cdb_tag   = 4'd2;
    in_cdb_nzcv  = 4'b1111;
    tick();
    clearInputs();
    tick();
    checkOutput("nzcv no wake fu_valid", 64'(out_fu_valid), 64'd0);
    checkOutput("nzcv no wake count", 64'(out_count), 64'd1);
    in_cdb_valid    = 1'b1;
    in_cdb_tag      = 4'd2;
    in_cdb_set_nzcv = 1'b1;
    in_cdb_nzcv     = 4'b0100;
    tick();
    clearInputs();
    checkOutput("nzcv capture fu_valid", 64'(out_fu_valid), 64'd0);
    tick();
    checkOutput("nzcv fu_valid", 64'(out_fu_valid), 64'd1);
    checkOutput("nzcv prev_nzcv", 64'(out_fu_prev_nzcv), 64'b0100);
    checkOutput("nzcv alu_op", 64'(out_fu_alu_op), 64'(ALU_CSEL));
    checkOutput("nzcv hw", 64'(out_fu_hw), 64'd3);
    checkOutput("nzcv set_CC", 64'(out_fu_set_CC), 64'd1);
    checkOutput("nzcv cond", 64'(out_fu_cond), 64'd5);
    checkOutput("nzcv dst_tag", 64'(out_fu_dst_tag), 64'd13);
    tick();

    // Flush with a full register and three queued ops drops everything, including the insert
    $display("[TB] flush sequence");
    clearInputs();
    in_fu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_ins_valid   = 1'b1;
      in_ins_dst_tag = 4'(k + 1);
      tick();
    end
    checkOutput("pre-flush count", 64'(out_count), 64'd3);
    checkOutput("pre-flush fu_valid", 64'(out_fu_valid), 64'd1);
    in_flush       = 1'b1;
    in_ins_valid   = 1'b1;
    in_ins_dst_tag = 4'd15;
    tick();
    checkOutput("flush count", 64'(out_count), 64'd0);
    checkOutput("flush fu_valid", 64'(out_fu_valid), 64'd0);
    checkOutput("flush ins_ready", 64'(out_ins_ready), 64'd1);
    clearInputs();
    tick();
    checkOutput("post-flush count", 64'(out_count), 64'd0);
    checkOutput("post-flush fu_valid", 64'(out_fu_valid), 64'd0);

    // Async reset in the middle of a stall clears state without waiting for an edge
    $display("[TB] async reset sequence");
    clearInputs();
    in_fu_ready    = 1'b0;
    in_ins_valid   = 1'b1;
    in_ins_val_a   = 64'hAA;
    in_ins_dst_tag = 4'd5;
    tick();
    in_ins_val_a   = 64'hBB;
    in_ins_dst_tag = 4'd6;
    tick();
    in_ins_valid = 1'b0;
    tick();
    checkOutput("stall hold fu_valid", 64'(out_fu_valid), 64'd1);
    checkOutput("stall hold dst_tag", 64'(out_fu_dst_tag), 64'd5);
    checkOutput("stall hold val_a", out_fu_val_a, 64'hAA);
    checkOutput("stall count", 64'(out_count), 64'd1);
    #2;
    in_rst_n = 1'b0;
    #1;
    checkOutput("async rst count", 64'(out_count), 64'd0);
    checkOutput("async rst fu_valid", 64'(out_fu_valid), 64'd0);
    checkOutput("async rst ins_ready", 64'(out_ins_ready), 64'd1);
    checkOutput("async rst dst_tag", 64'(out_fu_dst_tag), 64'd0);
    checkOutput("async rst val_a", out_fu_val_a, 64'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    clearInputs();
    tick();
    checkOutput("after rst count", 64'(out_count), 64'd0);
    checkOutput("after rst fu_valid", 64'(out_fu_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
